if_fetch_unit: RTL and testbench
================================

Name: if_fetch_unit

Overview:
- Instruction-fetch front end that drives the core's SRAM-like instruction port: inst_req/addr/addr_ok/data_ok toward the SRAM adapter or the AXI bridge.
- Tracks up to MAX_OUTST outstanding reads and buffers returned words in order.
- Presents {pc, inst, adel} to the decode stage over a valid/ready handshake.
- Handles redirects (branch/exception) by discarding stale responses.

Parameters:
- RESET_PC, 32'hbfc00000, first fetch address after reset.
- MAX_OUTST, 2, maximum accepted-but-unanswered requests (1..4).
- BUF_DEPTH, 2, output buffer entries (≥ MAX_OUTST).

Ports:
- clk  in  1  clock
- rst  in  1  reset
- redirect_valid  in  1  one-cycle redirect strobe
- redirect_pc  in  32  new fetch address
- inst_req  out  1  request valid
- inst_wr  out  1  constant 0
- inst_size  out  2  constant 2'b10
- inst_addr  out  32  request address
- inst_wdata  out  32  constant 0
- inst_addr_ok  in  1  request accepted
- inst_data_ok  in  1  response valid, in order
- inst_rdata  in  32  response data
- out_valid  out  1  fetch packet valid
- out_ready  in  1  decode accepts
- out_pc  out  32  packet PC
- out_inst  out  32  instruction, 0 when out_adel
- out_adel  out  1  PC misaligned (AdEL on fetch)

Behaviour:
- Reset is rst, synchronous, active-high; clock is clk.
- Reset values: inst_req=0, inst_addr=RESET_PC, out_valid=0, out_pc=0, out_inst=0, out_adel=0, all counters 0, stale flag 0.
- Credit: inst_req=1 iff (outst + buf_count) < BUF_DEPTH, outst < MAX_OUTST, pc[1:0]==0, and no pending redirect-to-misaligned entry.
- Once inst_req is raised, inst_req and inst_addr stay stable until inst_addr_ok. Requests are never withdrawn.
- Accept (inst_req & inst_addr_ok): outst+1, push pc into the PC-tag FIFO, pc <= pc+4 (32-bit wrap: 32'hfffffffc -> 0).
- Response (inst_data_ok): outst-1, pop the tag FIFO.
  - If discard_cnt>0: drop the word and decrement discard_cnt.
  - Otherwise push {tag, rdata, 0} into the output buffer.
- Accept and response in the same cycle: outst unchanged.
- Misaligned pc (pc[1:0]!=0): no bus request. Push {pc, 0, adel=1} into the buffer when it has space, then hold fetch (no pc advance) until the next redirect.
- Output: out_* show the buffer head. Pop on out_valid & out_ready. The buffer is a FIFO (order preserved). Zero-latency bypass from inst_data_ok to out_valid is not permitted: first out_valid comes the cycle after data_ok.
- Redirect (redirect_valid=1), with priority over all other events that cycle:
  - Flush the output buffer (same-cycle out pop is ignored).
  - discard_cnt <= outst_next − (response counted this cycle if it is not already discarded), i.e. every request accepted at or before this cycle whose response is not yet received gets discarded.
  - If a request is pending without addr_ok: it stays asserted at its old address, is marked stale, and is discarded on return. pc <= redirect_pc becomes visible after that accept.
  - Otherwise pc <= redirect_pc next cycle.
- Back-to-back redirects: the last one wins, and discard counts accumulate correctly.
- Full buffer: inst_req stays 0; no data loss is possible because credit includes outst.
- Reset mid-transaction: all state clears. Responses to pre-reset requests are not expected (the bus adapter resets too).

Optional Feature:
- Macro: IF_FETCH_PERF_CNT_EN.
- When defined: adds output ports perf_fetched (32, packets popped by decode) and perf_discarded (32, responses dropped by redirect). Both are 0 at reset and wrap at 2^32.
- When undefined: these ports and counters do not exist; behaviour is otherwise identical.

Decomposition:
- Shared package: RESET_PC default, INST_SIZE_WORD=2'b10, fetch packet struct {pc, inst, adel}, exception code constant EXC_ADEL=5'h04.
- Sub-module fetch_fifo, parameterised width/depth, with push/pop/count and synchronous flush. It is instantiated twice: PC-tag FIFO (width 32, depth MAX_OUTST) and output buffer (width 65, depth BUF_DEPTH).

Test Plan:
- Reset, then addr_ok=1 always, data_ok one cycle after accept, out_ready=1 -> first inst_addr=bfc00000; packets bfc00000, bfc00004, bfc00008 in order with matching rdata.
- out_ready=0 for 10 cycles -> at most 2 accepts, inst_req drops, no packet lost. Release -> packets continue from bfc00008.
- Two requests outstanding, redirect_pc=80000100 -> both responses dropped; next out_pc=80000100. perf_discarded=2 when IF_FETCH_PERF_CNT_EN is defined.
- Redirect while inst_req pending with addr_ok=0 for 3 cycles -> inst_addr unchanged until accept; that word is discarded; next request address is the redirect target.
- redirect_pc=80000102 -> no inst_req; one packet with out_pc=80000102, out_adel=1, out_inst=0; fetch holds until the next redirect.
- Redirect coincident with data_ok and out pop -> buffer empty next cycle, and the coincident response is not emitted.

Source files
------------

// File: rtl/if_fetch_unit_pkg.sv
// Shared types and constants for the instruction-fetch front end.
package if_fetch_unit_pkg;

    localparam logic [31:0] RESET_PC_DEF   = 32'hbfc00000;
    localparam logic [1:0]  INST_SIZE_WORD = 2'b10;
    localparam logic [4:0]  EXC_ADEL       = 5'h04;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        adel;
    } fetch_pkt_t;

    localparam int PKT_W = $bits(fetch_pkt_t);

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO with occupancy count and flush.
// Flush has priority over push and pop in the same cycle.
module fetch_fifo #(
    parameter int W = 32,
    parameter int D = 2,
    localparam int AW = (D > 1) ? $clog2(D) : 1,
    localparam int CW = $clog2(D + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          push,
    input  logic [W-1:0]  din,
    input  logic          pop,
    output logic [W-1:0]  dout,
    output logic [CW-1:0] count
);

    logic [W-1:0]  mem [D];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic          do_push;
    logic          do_pop;

    function automatic logic [AW-1:0] inc(input logic [AW-1:0] p);
        return (p == AW'(D - 1)) ? '0 : p + AW'(1);
    endfunction

    assign do_pop  = pop && (count != '0);
    assign do_push = push && ((count != CW'(D)) || do_pop);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= inc(wr_ptr);
            if (do_pop)  rd_ptr <= inc(rd_ptr);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch front end: SRAM-like request port, in-order buffer, redirects.
// Define IF_FETCH_PERF_CNT_EN to add fetched/discarded performance counters.
module if_fetch_unit
    import if_fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = RESET_PC_DEF,
    parameter int          MAX_OUTST = 2,
    parameter int          BUF_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        inst_req,
    output logic        inst_wr,
    output logic [1:0]  inst_size,
    output logic [31:0] inst_addr,
    output logic [31:0] inst_wdata,
    input  logic        inst_addr_ok,
    input  logic        inst_data_ok,
    input  logic [31:0] inst_rdata,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_pc,
    output logic [31:0] out_inst,
    output logic        out_adel
`ifdef IF_FETCH_PERF_CNT_EN
    ,
    output logic [31:0] perf_fetched,
    output logic [31:0] perf_discarded
`endif
);

    localparam int          OW  = $clog2(MAX_OUTST + 1);
    localparam int          BW  = $clog2(BUF_DEPTH + 1);
    localparam logic [31:0] BD  = BUF_DEPTH;
    localparam logic [31:0] MO  = MAX_OUTST;

    logic [31:0]   pc, pc_n;
    logic [31:0]   pend_pc, pend_pc_n;
    logic          stale, stale_n;
    logic          held;
    logic          adel_done, adel_done_n;
    logic [OW-1:0] outst, outst_n;
    logic [OW-1:0] discard, discard_n;
    logic [BW-1:0] buf_count;
    logic [31:0]   tag;
    fetch_pkt_t    buf_din;
    fetch_pkt_t    buf_head;

    logic accept, resp, drop, resp_push, adel_push;
    logic buf_push, buf_pop, misal, credit;

    assign misal  = pc[1:0] != 2'b00;
    assign credit = (32'(outst) + 32'(buf_count) < BD)
                 && (32'(outst) < MO) && !misal && !stale;

    // A raised request is held until accepted, even across redirects.
    assign inst_req   = !rst && (held || credit);
    assign inst_addr  = pc;
    assign inst_wr    = 1'b0;
    assign inst_size  = INST_SIZE_WORD;
    assign inst_wdata = 32'h0;

    assign accept    = inst_req && inst_addr_ok;
    assign resp      = inst_data_ok && (outst != '0);
    assign drop      = resp && (discard != '0);
    assign resp_push = resp && !drop;
    assign adel_push = misal && !adel_done && !resp_push
                    && (32'(buf_count) < BD);
    assign buf_push  = resp_push || adel_push;
    assign buf_pop   = out_valid && out_ready;
    assign outst_n   = outst + OW'(accept) - OW'(resp);

    assign out_valid = buf_count != '0;
    assign out_pc    = out_valid ? buf_head.pc   : 32'h0;
    assign out_inst  = out_valid ? buf_head.inst : 32'h0;
    assign out_adel  = out_valid && buf_head.adel;

    always_comb begin
        buf_din = '{pc: pc, inst: 32'h0, adel: 1'b1};
        if (resp_push) buf_din = '{pc: tag, inst: inst_rdata, adel: 1'b0};
    end

    always_comb begin
        pc_n        = pc;
        pend_pc_n   = pend_pc;
        stale_n     = stale;
        adel_done_n = adel_done || adel_push;
        discard_n   = discard - OW'(drop) + OW'(accept && stale);
        if (accept) begin
            pc_n    = stale ? pend_pc : pc + 32'd4;
            stale_n = 1'b0;
        end
        // Everything still in flight after this edge belongs to the old path.
        if (redirect_valid) begin
            discard_n   = outst_n;
            adel_done_n = 1'b0;
            pend_pc_n   = redirect_pc;
            if (inst_req && !inst_addr_ok) begin
                stale_n = 1'b1;
            end else begin
                pc_n    = redirect_pc;
                stale_n = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc        <= RESET_PC;
            pend_pc   <= RESET_PC;
            stale     <= 1'b0;
            held      <= 1'b0;
            adel_done <= 1'b0;
            discard   <= '0;
        end else begin
            pc        <= pc_n;
            pend_pc   <= pend_pc_n;
            stale     <= stale_n;
            held      <= inst_req && !inst_addr_ok;
            adel_done <= adel_done_n;
            discard   <= discard_n;
        end
    end

    fetch_fifo #(.W(32), .D(MAX_OUTST)) u_tag_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (1'b0),
        .push  (accept),
        .din   (pc),
        .pop   (resp),
        .dout  (tag),
        .count (outst)
    );

    fetch_fifo #(.W(PKT_W), .D(BUF_DEPTH)) u_out_buf (
        .clk   (clk),
        .rst   (rst),
        .flush (redirect_valid),
        .push  (buf_push),
        .din   (buf_din),
        .pop   (buf_pop),
        .dout  (buf_head),
        .count (buf_count)
    );

`ifdef IF_FETCH_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_fetched   <= 32'h0;
            perf_discarded <= 32'h0;
        end else begin
            if (buf_pop && !redirect_valid)
                perf_fetched <= perf_fetched + 32'd1;
            if (drop || (resp_push && redirect_valid))
                perf_discarded <= perf_discarded + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: random bus timing against an in-order packet model.
// Expected packets are the PC sequence from the last redirect target.
module tb_if_fetch_unit;

    localparam logic [31:0] RPC = 32'hbfc00000;

    logic        clk = 1'b0;
    logic        rst;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        inst_req;
    logic        inst_wr;
    logic [1:0]  inst_size;
    logic [31:0] inst_addr;
    logic [31:0] inst_wdata;
    logic        inst_addr_ok;
    logic        inst_data_ok;
    logic [31:0] inst_rdata;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_inst;
    logic        out_adel;
`ifdef IF_FETCH_PERF_CNT_EN
    logic [31:0] perf_fetched;
    logic [31:0] perf_discarded;
`endif

    always #5 clk = ~clk;

    if_fetch_unit dut (
        .clk            (clk),
        .rst            (rst),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .inst_req       (inst_req),
        .inst_wr        (inst_wr),
        .inst_size      (inst_size),
        .inst_addr      (inst_addr),
        .inst_wdata     (inst_wdata),
        .inst_addr_ok   (inst_addr_ok),
        .inst_data_ok   (inst_data_ok),
        .inst_rdata     (inst_rdata),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_pc         (out_pc),
        .out_inst       (out_inst),
        .out_adel       (out_adel)
`ifdef IF_FETCH_PERF_CNT_EN
        ,
        .perf_fetched   (perf_fetched),
        .perf_discarded (perf_discarded)
`endif
    );

    int          checks = 0;
    int          errors = 0;
    int          aok_p, dok_p, rdy_p;
    logic [31:0] q[$];
    logic [31:0] exp_pc;
    bit          exp_dead;
    int          npop;
    int          acc_cnt;
    bit          prev_held;
    logic [31:0] prev_addr;
    logic        s_req, s_valid, s_dok;
    logic [31:0] s_addr;
    bit          armed, fired;
    logic [31:0] armed_pc;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[7:0], a[31:8]} ^ 32'h3c5aa5c3;
    endfunction

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] want);
        checks++;
        assert (got === want) else begin
            errors++;
            $error("FAIL %s got %0h want %0h", tag, got, want);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc = 32'h0;
        inst_addr_ok = 1'b0;
        inst_data_ok = 1'b0;
        inst_rdata = 32'h0;
        out_ready = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_req", inst_req, 1'b0);
        chk("rst_addr", inst_addr, RPC);
        chk("rst_valid", out_valid, 1'b0);
        chk("rst_pc", out_pc, 32'h0);
        chk("rst_inst", out_inst, 32'h0);
        chk("rst_adel", out_adel, 1'b0);
        chk("rst_const", {inst_wr, inst_size, inst_wdata}, {1'b0, 2'b10, 32'h0});
        rst = 1'b0;
        q.delete();
        exp_pc = RPC;
        exp_dead = 1'b0;
        prev_held = 1'b0;
        npop = 0;
    endtask

    // One clock: drive at negedge, sample 1ns later, update the model.
    task automatic cyc(input bit rd, input logic [31:0] rpc);
        redirect_valid = rd;
        redirect_pc = rpc;
        inst_addr_ok = ($urandom_range(0, 99) < aok_p);
        out_ready = ($urandom_range(0, 99) < rdy_p);
        if (q.size() > 0 && $urandom_range(0, 99) < dok_p) begin
            inst_data_ok = 1'b1;
            inst_rdata = mem_word(q.pop_front());
        end else begin
            inst_data_ok = 1'b0;
            inst_rdata = $urandom;
        end
        #1;
        s_req = inst_req;
        s_addr = inst_addr;
        s_valid = out_valid;
        s_dok = inst_data_ok;
        if (armed && out_valid && inst_data_ok && out_ready) begin
            redirect_valid = 1'b1;
            redirect_pc = armed_pc;
            armed = 1'b0;
            fired = 1'b1;
        end
        if (prev_held) begin
            chk("req_hold", inst_req, 1'b1);
            chk("addr_hold", inst_addr, prev_addr);
        end
        if (exp_dead) begin
            chk("dead_req", inst_req, 1'b0);
            chk("dead_valid", out_valid, 1'b0);
        end
        if (out_valid && out_ready && !redirect_valid) begin
            npop++;
            chk("pop_pc", out_pc, exp_pc);
            if (exp_pc[1:0] != 2'b00) begin
                chk("pop_adel", out_adel, 1'b1);
                chk("pop_adel_inst", out_inst, 32'h0);
                exp_dead = 1'b1;
            end else begin
                chk("pop_adel", out_adel, 1'b0);
                chk("pop_inst", out_inst, mem_word(exp_pc));
                exp_pc = exp_pc + 32'd4;
            end
        end
        if (inst_req && inst_addr_ok) begin
            q.push_back(inst_addr);
            acc_cnt++;
            chk("acc_align", inst_addr[1:0], 2'b00);
            chk("outst_max", q.size() <= 2, 1'b1);
        end
        if (redirect_valid) begin
            exp_pc = redirect_pc;
            exp_dead = 1'b0;
        end
        prev_held = inst_req && !inst_addr_ok;
        prev_addr = inst_addr;
        @(negedge clk);
    endtask

    initial begin
        int          n0;
        logic [31:0] a_held;
        logic [31:0] r;
        armed = 1'b0;
        fired = 1'b0;
        acc_cnt = 0;
        do_reset();

        // In-order stream, and no same-cycle bypass from data_ok
        aok_p = 100; dok_p = 100; rdy_p = 100;
        cyc(1'b0, 32'h0);
        chk("first_req", s_req, 1'b1);
        chk("first_addr", s_addr, RPC);
        cyc(1'b0, 32'h0);
        chk("first_dok", s_dok, 1'b1);
        chk("no_bypass", s_valid, 1'b0);
        cyc(1'b0, 32'h0);
        chk("first_valid", s_valid, 1'b1);
        repeat (6) cyc(1'b0, 32'h0);
        chk("t1_pops", npop >= 3, 1'b1);

        // Decode stall: credit caps accepts, nothing lost on release
        rdy_p = 0;
        acc_cnt = 0;
        repeat (10) cyc(1'b0, 32'h0);
        chk("stall_acc", acc_cnt <= 2, 1'b1);
        chk("stall_req", s_req, 1'b0);
        rdy_p = 100;
        n0 = npop;
        repeat (10) cyc(1'b0, 32'h0);
        chk("stall_resume", npop > n0 + 2, 1'b1);

        // Redirect with two responses in flight
        dok_p = 0;
        for (int i = 0; i < 20; i++) begin
            cyc(1'b0, 32'h0);
            if (q.size() == 2) break;
        end
        chk("t3_two_outst", q.size(), 2);
        cyc(1'b1, 32'h80000100);
        dok_p = 100;
        n0 = npop;
        repeat (10) cyc(1'b0, 32'h0);
        chk("t3_resume", npop > n0, 1'b1);

        // Redirect while a request waits for addr_ok
        aok_p = 0;
        for (int i = 0; i < 10; i++) begin
            cyc(1'b0, 32'h0);
            if (s_req) break;
        end
        chk("t4_req", s_req, 1'b1);
        a_held = s_addr;
        cyc(1'b1, 32'h80000200);
        repeat (2) cyc(1'b0, 32'h0);
        chk("t4_hold_addr", s_addr, a_held);
        aok_p = 100;
        cyc(1'b0, 32'h0);
        chk("t4_stale_addr", s_addr, a_held);
        cyc(1'b0, 32'h0);
        chk("t4_target_req", s_req, 1'b1);
        chk("t4_target_addr", s_addr, 32'h80000200);
        n0 = npop;
        repeat (8) cyc(1'b0, 32'h0);
        chk("t4_resume", npop > n0, 1'b1);

        // Misaligned target: one AdEL packet, then fetch holds
        cyc(1'b1, 32'h80000102);
        n0 = npop;
        repeat (8) cyc(1'b0, 32'h0);
        chk("t5_one_pkt", npop - n0, 1);
        chk("t5_no_req", s_req, 1'b0);

        // Address wrap at the top of memory
        cyc(1'b1, 32'hfffffff8);
        n0 = npop;
        repeat (12) cyc(1'b0, 32'h0);
        chk("t5_wrap", npop - n0 >= 3, 1'b1);

        // Redirect coincident with data_ok and an out pop
        armed_pc = 32'h80000400;
        armed = 1'b1;
        fired = 1'b0;
        for (int i = 0; i < 20; i++) begin
            cyc(1'b0, 32'h0);
            if (fired) break;
        end
        armed = 1'b0;
        chk("t6_fired", fired, 1'b1);
        cyc(1'b0, 32'h0);
        chk("t6_flushed", s_valid, 1'b0);
        n0 = npop;
        repeat (8) cyc(1'b0, 32'h0);
        chk("t6_resume", npop > n0, 1'b1);

        // Reset mid-stream, then random bus timing and redirects
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            if (i % 200 == 0) begin
                aok_p = $urandom_range(30, 100);
                dok_p = $urandom_range(30, 100);
                rdy_p = $urandom_range(30, 100);
            end
            r = $urandom;
            if ($urandom_range(0, 7) == 0) r[1:0] = 2'($urandom_range(1, 3));
            else r[1:0] = 2'b00;
            cyc($urandom_range(0, 99) < 3, r);
        end
        chk("rand_progress", npop > 100, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
